aes_cmd_ctrl: RTL and testbench

Parametrised command controller for the AES accelerator. It accepts tagged commands over a valid/ready handshake and sequences an external key-expansion unit and an external round engine. It adds chaining modes (ECB, CBC, CTR), an IV/counter register, key-presence checking and error responses. It returns one tagged response per command over a valid/ready output, and replaces the single-mode top-level controller as the front end of the crypto core.

---
 rtl/aes_ctrl_pkg.sv | 29 ++
 rtl/aes_chain_unit.sv | 45 ++++
 rtl/aes_cmd_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_aes_cmd_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the AES command controller.
package aes_ctrl_pkg;

  localparam int AES_BLK_W = 128;

  typedef logic [2:0] op_t;

  localparam op_t OP_LOAD_KEY = 3'd0;
  localparam op_t OP_LOAD_IV  = 3'd1;
  localparam op_t OP_ECB_ENC  = 3'd2;
  localparam op_t OP_ECB_DEC  = 3'd3;
  localparam op_t OP_CBC_ENC  = 3'd4;
  localparam op_t OP_CBC_DEC  = 3'd5;
  localparam op_t OP_CTR      = 3'd6;
  localparam op_t OP_ILLEGAL  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEY,
    ST_ENG,
    ST_RESP
  } state_e;

  // Only the two decrypting modes run the round engine backwards; CTR always encrypts.
  function automatic logic op_is_dec(input op_t op);
    return (op == OP_ECB_DEC) || (op == OP_CBC_DEC);
  endfunction

endpackage

// File: rtl/aes_chain_unit.sv
// Combinational chaining-mode datapath: engine input, block result and next IV/counter.
module aes_chain_unit
  import aes_ctrl_pkg::*;
#(
  parameter int CTR_W = 32
) (
  input  op_t                  op_i,
  input  logic [AES_BLK_W-1:0] blk_i,
  input  logic [AES_BLK_W-1:0] iv_i,
  input  logic [AES_BLK_W-1:0] eng_out_i,
  output logic [AES_BLK_W-1:0] eng_in_o,
  output logic [AES_BLK_W-1:0] result_o,
  output logic [AES_BLK_W-1:0] next_iv_o
);

  // The counter field wraps inside the mask; upper IV bits never see the carry.
  localparam logic [AES_BLK_W-1:0] CTR_MASK = {AES_BLK_W{1'b1}} >> (AES_BLK_W - CTR_W);

  logic [AES_BLK_W-1:0] iv_inc;
  assign iv_inc = iv_i + {{(AES_BLK_W-1){1'b0}}, 1'b1};

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    eng_in_o  = blk_i;
    result_o  = eng_out_i;
    next_iv_o = iv_i;
    case (op_i)
      OP_CBC_ENC: begin
        eng_in_o  = blk_i ^ iv_i;
        next_iv_o = eng_out_i;
      end
      OP_CBC_DEC: begin
        result_o  = eng_out_i ^ iv_i;
        next_iv_o = blk_i;
      end
      OP_CTR: begin
        eng_in_o  = iv_i;
        result_o  = eng_out_i ^ blk_i;
        next_iv_o = (iv_i & ~CTR_MASK) | (iv_inc & CTR_MASK);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/aes_cmd_ctrl.sv
// Tagged command front end: sequences key expansion and the round engine, one command in flight.
module aes_cmd_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int KEY_W = 256,
  parameter int TAG_W = 4,
  parameter int CTR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [KEY_W-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_W-1:0]     out_tag,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 out_err,
  output logic                 busy,
  output logic                 key_start,
  output logic [KEY_W-1:0]     key_data,
  input  logic                 key_done,
  output logic                 eng_start,
  output logic                 eng_dir,
  output logic [AES_BLK_W-1:0] eng_in,
  input  logic [AES_BLK_W-1:0] eng_out,
  input  logic                 eng_done
);

  state_e               state_q, state_d;
  op_t                  op_q, op_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [AES_BLK_W-1:0] blk_q, blk_d;
  logic [AES_BLK_W-1:0] iv_q, iv_d;
  logic [AES_BLK_W-1:0] out_data_q, out_data_d;
  logic                 out_err_q, out_err_d;
  logic                 key_loaded_q, key_loaded_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic [AES_BLK_W-1:0] eng_in_q, eng_in_d;
  logic                 key_start_q, key_start_d;
  logic                 eng_start_q, eng_start_d;

  logic [AES_BLK_W-1:0] in_blk;
  assign in_blk = in_data[KEY_W-1 -: AES_BLK_W];

  // In IDLE the chain unit sees the incoming command so eng_in can be registered at accept;
  // afterwards it sees the registered command, and IV does not move until eng_done.
  op_t                  chain_op;
  logic [AES_BLK_W-1:0] chain_blk;
  logic [AES_BLK_W-1:0] chain_eng_in, chain_result, chain_next_iv;

  assign chain_op  = (state_q == ST_IDLE) ? op_t'(in_op) : op_q;
  assign chain_blk = (state_q == ST_IDLE) ? in_blk : blk_q;

  aes_chain_unit #(.CTR_W(CTR_W)) u_chain (
    .op_i      (chain_op),
    .blk_i     (chain_blk),
    .iv_i      (iv_q),
    .eng_out_i (eng_out),
    .eng_in_o  (chain_eng_in),
    .result_o  (chain_result),
    .next_iv_o (chain_next_iv)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    tag_d        = tag_q;
    blk_d        = blk_q;
    iv_d         = iv_q;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    key_loaded_d = key_loaded_q;
    key_d        = key_q;
    eng_in_d     = eng_in_q;
    key_start_d  = 1'b0;
    eng_start_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d       = op_t'(in_op);
          tag_d      = in_tag;
          blk_d      = in_blk;
          out_data_d = '0;
          out_err_d  = 1'b0;
          case (op_t'(in_op))
            OP_LOAD_KEY: begin
              key_d        = in_data;
              key_loaded_d = 1'b0;
              key_start_d  = 1'b1;
              state_d      = ST_KEY;
            end
            OP_LOAD_IV: begin
              iv_d    = in_blk;
              state_d = ST_RESP;
            end
            OP_ILLEGAL: begin
              out_err_d = 1'b1;
              state_d   = ST_RESP;
            end
            default: begin
              if (key_loaded_q) begin
                eng_in_d    = chain_eng_in;
                eng_start_d = 1'b1;
                state_d     = ST_ENG;
              end else begin
                out_err_d = 1'b1;
                state_d   = ST_RESP;
              end
            end
          endcase
        end
      end
      // A done coinciding with the start pulse cannot belong to this command.
      ST_KEY: begin
        if (key_done && !key_start_q) begin
          key_loaded_d = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_ENG: begin
        if (eng_done && !eng_start_q) begin
          out_data_d = chain_result;
          iv_d       = chain_next_iv;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_LOAD_KEY;
      tag_q        <= '0;
      blk_q        <= '0;
      iv_q         <= '0;
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      key_loaded_q <= 1'b0;
      key_q        <= '0;
      eng_in_q     <= '0;
      key_start_q  <= 1'b0;
      eng_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      blk_q        <= blk_d;
      iv_q         <= iv_d;
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      key_loaded_q <= key_loaded_d;
      key_q        <= key_d;
      eng_in_q     <= eng_in_d;
      key_start_q  <= key_start_d;
      eng_start_q  <= eng_start_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_RESP);
  assign out_tag   = tag_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign key_start = key_start_q;
  assign key_data  = key_q;
  assign eng_start = eng_start_q;
  assign eng_dir   = op_is_dec(op_q);
  assign eng_in    = eng_in_q;

endmodule

// File: tb/tb_aes_cmd_ctrl.sv
// Directed bench for aes_cmd_ctrl with key and round-engine BFMs (engine latency 10 cycles).
module tb_aes_cmd_ctrl;
  localparam int KEY_W = 128;
  localparam int TAG_W = 4;
  localparam int CTR_W = 32;

  localparam logic [127:0] K   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MIX = 128'ha5a5a5a5_3c3c3c3c_0f0f0f0f_96969696;
  localparam logic [127:0] IV_CTR  = 128'h000000000000000000000001ffffffff;
  localparam logic [127:0] IV_CTR2 = 128'h00000000000000000000000100000000;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  logic [2:0] in_op;
  logic [TAG_W-1:0] in_tag;
  logic [KEY_W-1:0] in_data;
  logic out_valid, out_ready;
  logic [TAG_W-1:0] out_tag;
  logic [127:0] out_data;
  logic out_err, busy;
  logic key_start, key_done;
  logic [KEY_W-1:0] key_data;
  logic eng_start, eng_dir, eng_done;
  logic [127:0] eng_in, eng_out;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aes_cmd_ctrl #(.KEY_W(KEY_W), .TAG_W(TAG_W), .CTR_W(CTR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_tag(in_tag), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
    .out_err(out_err), .busy(busy),
    .key_start(key_start), .key_data(key_data), .key_done(key_done),
    .eng_start(eng_start), .eng_dir(eng_dir), .eng_in(eng_in), .eng_out(eng_out),
    .eng_done(eng_done)
  );

  // Stand-in cipher: the FIPS-197 pair is exact, everything else is an invertible scramble.
  function automatic logic [127:0] eng_model(input logic [127:0] x, input logic dir);
    logic [127:0] y;
    if (!dir) begin
      if (x == PT) return CT;
      return {x[119:0], x[127:120]} ^ MIX;
    end
    if (x == CT) return PT;
    y = x ^ MIX;
    return {y[7:0], y[127:8]};
  endfunction

  // Engine and key BFMs are external units: they are not reset with the controller.
  int           eng_cnt = 0;
  int           key_cnt = 0;
  int           eng_starts = 0;
  int           eng_dones = 0;
  logic [127:0] bfm_in = '0;
  logic         bfm_dir = 1'b0;

  always @(posedge clk) begin
    eng_done <= 1'b0;
    key_done <= 1'b0;
    if (eng_cnt == 1) begin
      eng_done  <= 1'b1;
      eng_out   <= eng_model(bfm_in, bfm_dir);
      eng_dones <= eng_dones + 1;
    end
    if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
    if (eng_start) begin
      eng_cnt    <= 10;
      bfm_in     <= eng_in;
      bfm_dir    <= eng_dir;
      eng_starts <= eng_starts + 1;
    end
    if (key_cnt == 1) key_done <= 1'b1;
    if (key_cnt > 0) key_cnt <= key_cnt - 1;
    if (key_start) key_cnt <= 3;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a command at the falling edge; it is accepted on the following rising edge.
  task automatic send(input logic [2:0] op, input logic [TAG_W-1:0] tag, input logic [127:0] data);
    @(negedge clk);
    check("in_ready_before_send", {127'b0, in_ready}, 128'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_tag   = tag;
    in_data  = data;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic get_resp(output logic [127:0] data, output logic [TAG_W-1:0] tag,
                          output logic err);
    int waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("resp_within_budget", {127'b0, out_valid}, 128'd1);
    data = out_data;
    tag  = out_tag;
    err  = out_err;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  logic [127:0]     r_data, ct2, ctr_ks;
  logic [TAG_W-1:0] r_tag;
  logic             r_err, seen_valid;
  int               starts_snap, dones_snap;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_op = '0; in_tag = '0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  {127'b0, in_ready},  128'd1);
    check("rst_busy",      {127'b0, busy},      128'd0);
    check("rst_out_valid", {127'b0, out_valid}, 128'd0);
    check("rst_out_data",  out_data,            128'd0);
    check("rst_out_tag",   {124'b0, out_tag},   128'd0);
    check("rst_out_err",   {127'b0, out_err},   128'd0);
    check("rst_starts",    {126'b0, key_start, eng_start}, 128'd0);
    rst = 1'b0;

    // 1: encrypt without a key -> immediate error response
    send(3'd2, 4'd5, PT);
    @(negedge clk);
    check("t1_valid_next_cycle", {127'b0, out_valid}, 128'd1);
    check("t1_in_ready_low",     {127'b0, in_ready},  128'd0);
    get_resp(r_data, r_tag, r_err);
    check("t1_err",  {127'b0, r_err}, 128'd1);
    check("t1_data", r_data,          128'd0);
    check("t1_tag",  {124'b0, r_tag}, 128'd5);
    check("t1_no_engine", 128'(eng_starts), 128'd0);

    // 2: LOAD_KEY then ECB_ENC
    send(3'd0, 4'd1, K);
    @(negedge clk);
    check("t2_key_start", {127'b0, key_start}, 128'd1);
    check("t2_key_data",  key_data,            K);
    @(negedge clk);
    check("t2_key_start_pulse", {127'b0, key_start}, 128'd0);
    get_resp(r_data, r_tag, r_err);
    check("t2_key_err",  {127'b0, r_err}, 128'd0);
    check("t2_key_data_resp", r_data,     128'd0);
    check("t2_key_tag",  {124'b0, r_tag}, 128'd1);
    send(3'd2, 4'd2, PT);
    @(negedge clk);
    check("t2_eng_start", {127'b0, eng_start}, 128'd1);
    check("t2_eng_in",    eng_in,              PT);
    check("t2_eng_dir",   {127'b0, eng_dir},   128'd0);
    get_resp(r_data, r_tag, r_err);
    check("t2_ecb_data", r_data,          CT);
    check("t2_ecb_err",  {127'b0, r_err}, 128'd0);
    check("t2_ecb_tag",  {124'b0, r_tag}, 128'd2);

    // 3: CBC encrypt two blocks, then decrypt both back
    send(3'd1, 4'd3, 128'd0);
    @(negedge clk);
    check("t3_iv_valid_next", {127'b0, out_valid}, 128'd1);
    get_resp(r_data, r_tag, r_err);
    check("t3_iv_data", r_data, 128'd0);
    send(3'd4, 4'd4, PT);
    @(negedge clk);
    check("t3_cbc1_eng_in", eng_in, PT);
    get_resp(r_data, r_tag, r_err);
    check("t3_cbc1_data", r_data, CT);
    send(3'd4, 4'd6, PT);
    @(negedge clk);
    check("t3_cbc2_eng_in", eng_in, PT ^ CT);
    get_resp(r_data, r_tag, r_err);
    ct2 = eng_model(PT ^ CT, 1'b0);
    check("t3_cbc2_data", r_data, ct2);
    send(3'd1, 4'd7, 128'd0);
    get_resp(r_data, r_tag, r_err);
    send(3'd5, 4'd8, CT);
    @(negedge clk);
    check("t3_dec1_dir",    {127'b0, eng_dir}, 128'd1);
    check("t3_dec1_eng_in", eng_in,            CT);
    get_resp(r_data, r_tag, r_err);
    check("t3_dec1_data", r_data, PT);
    send(3'd5, 4'd9, ct2);
    @(negedge clk);
    check("t3_dec2_eng_in", eng_in, ct2);
    get_resp(r_data, r_tag, r_err);
    check("t3_dec2_data", r_data, PT);

    // 4: CTR with counter wrap in the low 32 bits
    send(3'd1, 4'd10, IV_CTR);
    get_resp(r_data, r_tag, r_err);
    send(3'd6, 4'd11, PT);
    @(negedge clk);
    check("t4_ctr1_eng_in", eng_in,            IV_CTR);
    check("t4_ctr1_dir",    {127'b0, eng_dir}, 128'd0);
    get_resp(r_data, r_tag, r_err);
    ctr_ks = eng_model(IV_CTR, 1'b0);
    check("t4_ctr1_data", r_data, ctr_ks ^ PT);
    send(3'd6, 4'd12, CT);
    @(negedge clk);
    check("t4_ctr2_eng_in", eng_in, IV_CTR2);
    get_resp(r_data, r_tag, r_err);
    ctr_ks = eng_model(IV_CTR2, 1'b0);
    check("t4_ctr2_data", r_data, ctr_ks ^ CT);

    // 5: illegal op with response back-pressure
    send(3'd7, 4'd13, PT);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold_valid",    {127'b0, out_valid}, 128'd1);
      check("t5_hold_in_ready", {127'b0, in_ready},  128'd0);
      check("t5_hold_err",      {127'b0, out_err},   128'd1);
      check("t5_hold_data",     out_data,            128'd0);
      check("t5_hold_tag",      {124'b0, out_tag},   128'd13);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("t5_released_valid", {127'b0, out_valid}, 128'd0);
    check("t5_released_ready", {127'b0, in_ready},  128'd1);

    // 6: reset during ENG; the stale eng_done must not produce a response
    send(3'd2, 4'd14, PT);
    repeat (4) @(negedge clk);
    check("t6_in_eng_busy", {127'b0, busy}, 128'd1);
    dones_snap = eng_dones;
    rst = 1'b1;
    #1;
    check("t6_rst_busy",     {127'b0, busy},      128'd0);
    check("t6_rst_in_ready", {127'b0, in_ready},  128'd1);
    check("t6_rst_valid",    {127'b0, out_valid}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("t6_stale_done_fired", 128'(eng_dones - dones_snap), 128'd1);
    check("t6_no_out_valid",     {127'b0, seen_valid},         128'd0);
    check("t6_out_data_cleared", out_data,                     128'd0);
    starts_snap = eng_starts;
    send(3'd2, 4'd15, PT);
    get_resp(r_data, r_tag, r_err);
    check("t6_nokey_err",  {127'b0, r_err}, 128'd1);
    check("t6_nokey_data", r_data,          128'd0);
    check("t6_nokey_tag",  {124'b0, r_tag}, 128'd15);
    check("t6_nokey_no_engine", 128'(eng_starts - starts_snap), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

endmodule
